// File: rtl/sprite_palette_lut_if.sv
// Pixel-request, palette-write and colour-output signals of sprite_palette_lut.
// The master modport is the sprite-fetch side, the slave modport is the palette block.
interface sprite_palette_lut_if #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned NUM_BANKS = 4
);
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned PPW    = WORD_W / IDX_W;
  localparam int unsigned SEL_W  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned RGB_W  = 24;

  logic              pal_we;
  logic [BANK_W-1:0] pal_bank;
  logic [IDX_W-1:0]  pal_addr;
  logic [RGB_W-1:0]  pal_rgb;

  logic              pix_valid;
  logic [WORD_W-1:0] pix_word;
  logic [SEL_W-1:0]  pix_sel;
  logic [BANK_W-1:0] pix_bank;
  logic [RGB_W-1:0]  bg_rgb;

  logic              ready;
  logic              out_valid;
  logic [7:0]        sprite_r;
  logic [7:0]        sprite_g;
  logic [7:0]        sprite_b;
  logic              out_transparent;

  modport master (
    output pal_we, pal_bank, pal_addr, pal_rgb,
    output pix_valid, pix_word, pix_sel, pix_bank, bg_rgb,
    input  ready, out_valid, sprite_r, sprite_g, sprite_b, out_transparent
  );

  modport slave (
    input  pal_we, pal_bank, pal_addr, pal_rgb,
    input  pix_valid, pix_word, pix_sel, pix_bank, bg_rgb,
    output ready, out_valid, sprite_r, sprite_g, sprite_b, out_transparent
  );
endinterface

// File: rtl/sprite_palette_lut.sv
// Multi-bank writable colour palette with a 2-stage lookup pipeline and colour-key
// substitution. A post-reset sweep clears every entry before lookups are accepted.
module sprite_palette_lut #(
  parameter int unsigned     WORD_W     = 16,
  parameter int unsigned     IDX_W      = 8,
  parameter int unsigned     NUM_BANKS  = 4,
  parameter logic [IDX_W-1:0] TRANSP_IDX = '1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  sprite_palette_lut_if.slave  bus
);
  localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned ADDR_W  = BANK_W + IDX_W;
  localparam int unsigned DEPTH   = NUM_BANKS * ENTRIES;
  localparam int unsigned RGB_W   = 24;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              w_clr_last;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [RGB_W-1:0]  w_wdata;
  logic              w_wr_bank_ok;

  logic [RGB_W-1:0]  r_mem [DEPTH];

  logic              r_ready;
  logic              r_s1_valid;
  logic [IDX_W-1:0]  r_s1_idx;
  logic [BANK_W-1:0] r_s1_bank;
  logic [RGB_W-1:0]  r_s1_bg;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_rd_bank_ok;
  logic [ADDR_W-1:0] w_raddr;

  logic              r_out_valid;
  logic              r_out_transp;
  logic [RGB_W-1:0]  r_out_rgb;

  assign w_clr_last   = (r_clr_cnt == ADDR_W'(DEPTH - 1));
  assign w_wr_bank_ok = (32'(bus.pal_bank) < NUM_BANKS);
  assign w_rd_bank_ok = (32'(r_s1_bank) < NUM_BANKS);
  assign w_raddr      = {r_s1_bank, r_s1_idx};
  assign w_sel_idx    = bus.pix_word[int'(bus.pix_sel) * int'(IDX_W) +: IDX_W];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and the single palette write port (clear sweep in INIT, user writes in RUN).
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        if (w_clr_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.pal_we && w_wr_bank_ok) begin
          w_we    = 1'b1;
          w_waddr = {bus.pal_bank, bus.pal_addr};
          w_wdata = bus.pal_rgb;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      if (r_state == ST_INIT) begin
        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
      end
      r_ready <= (w_state_nxt == ST_RUN);
    end
  end

  // Palette storage has no reset; the INIT sweep clears it.
  always_ff @(posedge Clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // S1: capture the selected index and lookup context.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_bank  <= '0;
      r_s1_bg    <= '0;
    end else begin
      r_s1_valid <= bus.pix_valid && (r_state == ST_RUN);
      if (bus.pix_valid) begin
        r_s1_idx  <= w_sel_idx;
        r_s1_bank <= bus.pix_bank;
        r_s1_bg   <= bus.bg_rgb;
      end
    end
  end

  // S2: palette read happens on the same edge as any write, so a colliding read sees old data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_transp <= 1'b0;
      r_out_rgb    <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        if (!w_rd_bank_ok) begin
          r_out_transp <= 1'b0;
          r_out_rgb    <= '0;
        end else if (r_s1_idx == TRANSP_IDX) begin
          r_out_transp <= 1'b1;
          r_out_rgb    <= r_s1_bg;
        end else begin
          r_out_transp <= 1'b0;
          r_out_rgb    <= r_mem[w_raddr];
        end
      end
    end
  end

  assign bus.ready           = r_ready;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_transparent = r_out_transp;
  assign bus.sprite_r        = r_out_rgb[23:16];
  assign bus.sprite_g        = r_out_rgb[15:8];
  assign bus.sprite_b        = r_out_rgb[7:0];
endmodule
